// File: rtl/fetch_ctrl.sv
// fetch_ctrl: boot/run sequencer for fetch_stage plus arbitration of the single
// synchronous instruction-memory port between instruction fetch and a program
// loader.
//
// Handshake semantics (single description for all ports):
//   - ld_req is a level request held by the loader with stable ld_addr/ld_wdata;
//     a write is performed in exactly the cycles where ld_gnt=1 (same cycle,
//     combinational). The first ld_req cycle in RUN only switches to LOAD.
//   - redirect_valid is a one-cycle pulse; it is applied immediately when the
//     fetch advances (fe_clk_en=1), otherwise it is parked in a single pending
//     slot (newest wins) and applied on the first advancing RUN cycle.
//   - imem holds its output register whenever imem_en=0, so fetch data stays
//     aligned with fetch_pc across stalls; instr_valid qualifies that data.
module fetch_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [ADDR_W-1:0] fetch_next,
  output logic              fe_sync_rst,
  output logic              fe_clk_en,
  output logic              fe_jmp,
  output logic [ADDR_W-1:0] fe_target,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              instr_valid,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_LOAD   = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_boot_cnt;
  logic                r_pend_valid;
  logic [ADDR_W-1:0]   r_pend_target;
  logic                r_instr_valid;

  logic                w_in_run;
  logic                w_adv;
  logic                w_redir;

  // Fetch advances only in RUN when neither the backend nor the loader holds it.
  assign w_in_run  = (r_state == S_RUN);
  assign w_adv     = w_in_run && !stall_in && !ld_req;
  assign w_redir   = redirect_valid || r_pend_valid;

  assign fe_sync_rst = (r_state == S_BOOT);
  assign fe_clk_en   = w_adv;
  assign fe_jmp      = w_adv && w_redir;
  // A fresh redirect beats the parked one.
  assign fe_target   = redirect_valid ? redirect_target : r_pend_target;
  assign ld_gnt      = (r_state == S_LOAD) && ld_req;
  assign instr_valid = r_instr_valid;
  assign busy        = !w_in_run;
  assign dbg_state   = r_state;

  // imem port mux: fetch read in RUN, loader write in LOAD, refetch of fetch_pc in RESUME.
  always_comb begin
    imem_addr  = fetch_next;
    imem_en    = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = '0;
    case (r_state)
      S_RUN: begin
        imem_addr = fetch_next;
        imem_en   = w_adv;
      end
      S_LOAD: begin
        imem_addr  = ld_addr;
        imem_en    = ld_req;
        imem_we    = ld_req;
        imem_wdata = ld_wdata;
      end
      S_RESUME: begin
        imem_addr = fetch_pc;
        imem_en   = 1'b1;
      end
      default: begin
        imem_addr = fetch_next;
      end
    endcase
  end

  // Sequencer FSM: boot countdown, run/load/resume transitions, instr_valid tracking.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (r_boot_cnt == BOOT_LAST) begin
            r_state    <= S_RUN;
            r_boot_cnt <= '0;
          end else begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (ld_req) begin
            r_state       <= S_LOAD;
            r_instr_valid <= 1'b0;
          end else if (!stall_in) begin
            r_instr_valid <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!ld_req) begin
            r_state <= S_RESUME;
          end
        end
        S_RESUME: begin
          r_state       <= S_RUN;
          r_instr_valid <= 1'b1;
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  // Pending redirect slot: consumed on any advance, refilled by a redirect that cannot advance.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (r_state != S_BOOT) begin
      if (w_adv) begin
        r_pend_valid <= 1'b0;
      end else if (redirect_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= redirect_target;
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for fetch_stage and the shared instruction-memory port. Generates the boot-time sync reset pulse, the fetch clock enable, and redirect/jump control. Arbitrates the single synchronous imem port between instruction fetch and a program loader write port. Sits between the backend (stall/redirect), fetch_stage, and the instruction memory.

Parameters:
BOOT_CYCLES, 4, cycles fe_sync_rst is held after async reset release (>=1)
ADDR_W, 30, word-address width
DATA_W, 32, instruction/write-data width

Ports:
clk  in  1  clock
async_rst_n  in  1  asynchronous active-low reset
stall_in  in  1  backend stall; fetch must not advance
redirect_valid  in  1  redirect request (one-cycle pulse)
redirect_target  in  ADDR_W  redirect word address
fetch_pc  in  ADDR_W  fetch_stage current PC (to_pipe)
fetch_next  in  ADDR_W  fetch_stage next PC (to_address)
fe_sync_rst  out  1  to fetch_stage sync_rst
fe_clk_en  out  1  to fetch_stage clk_en
fe_jmp  out  1  to fetch_stage jmp
fe_target  out  ADDR_W  to fetch_stage data_in
ld_req  in  1  loader requests imem write port
ld_addr  in  ADDR_W  loader write address
ld_wdata  in  DATA_W  loader write data
ld_gnt  out  1  loader write performed this cycle
imem_addr  out  ADDR_W  imem address
imem_en  out  1  imem access enable (output register holds when 0)
imem_we  out  1  imem write enable
imem_wdata  out  DATA_W  imem write data
instr_valid  out  1  imem read data corresponds to fetch_pc
busy  out  1  not in RUN

Behaviour:
- Async reset: state=BOOT, boot counter=0, pending redirect cleared, instr_valid=0, fe_sync_rst=1, fe_clk_en=0, fe_jmp=0, ld_gnt=0, imem_en=0, imem_we=0, busy=1.
- States: BOOT, RUN, LOAD, RESUME.
- BOOT: fe_sync_rst=1, fe_clk_en=0, imem_en=0 for exactly BOOT_CYCLES clocks after reset release, then RUN. ld_req and redirect_valid ignored (not latched).
- RUN: fe_clk_en = !stall_in && !ld_req; imem_addr=fetch_next, imem_en=fe_clk_en, imem_we=0. Stall holds imem output so data stays aligned with fetch_pc.
- Redirect: if redirect_valid or pending set and fe_clk_en=1, fe_jmp=1, fe_target=redirect_target (or latched target); pending cleared. If fe_clk_en=0 (stall, LOAD, RESUME), target latched into pending; applied on first advancing RUN cycle. New redirect_valid overwrites pending (newest wins). fe_jmp=0 whenever fe_clk_en=0.
- instr_valid: registered; set the cycle after an advancing RUN cycle, held during stall, cleared on entering LOAD, set again the cycle after RESUME.
- ld_req in RUN: priority over advance and redirect; this cycle fe_clk_en=0; next cycle LOAD.
- LOAD: fe_clk_en=0; each cycle ld_req=1: imem_addr=ld_addr, imem_en=1, imem_we=1, imem_wdata=ld_wdata, ld_gnt=1 (combinational, same cycle). ld_req=0 -> RESUME. ld_gnt=0 in all other states.
- RESUME (1 cycle): imem_addr=fetch_pc, imem_en=1, imem_we=0, fe_clk_en=0; next RUN, instr_valid=1.
- busy = (state != RUN).
- Reset asserted mid-LOAD: write aborted immediately, BOOT re-entered, pending dropped.

Test Plan:
- Reset release, BOOT_CYCLES=4 -> fe_sync_rst high 4 cycles, then fe_clk_en=1; fetch_next sequence 0,1,2; instr_valid rises cycle after first advance.
- stall_in high 3 cycles at fetch_pc=5 -> fe_clk_en=0, imem_en=0, fetch_pc stays 5, instr_valid stays 1; resumes at 6.
- redirect_valid target 0x100 while stalled -> no fe_jmp during stall; first unstalled cycle fe_jmp=1, fe_target=0x100; second redirect 0x200 while stalled overrides 0x100.
- ld_req for 3 writes (addr 0x10..0x12, data 0xA5A5_0000+i) -> ld_gnt 3 cycles, imem_we=1 with matching addr/data; then RESUME with imem_addr=fetch_pc, then RUN, instr_valid=1.
- redirect_valid during LOAD -> held pending, fe_jmp=1 on first RUN advance after RESUME.
- async_rst_n low mid-LOAD -> imem_we drops same cycle, busy=1, BOOT sequence repeats, pending cleared (no fe_jmp afterwards).
